// File: rtl/neighbor_count_sequencer.sv
// Game-of-Life cell evaluator: counts live neighbours two at a time over four
// cycles, then reports the count and the Conway next-generation state.
module neighbor_count_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] neighbors,
  input  logic       alive,
  output logic       busy,
  output logic       done,
  output logic [3:0] count,
  output logic       next_alive
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE_ST} state_t;

  state_t     state;
  logic [7:0] nbr_q;
  logic       alive_q;
  logic [1:0] idx;

  logic [1:0] pair_bits;
  logic [2:0] pair_sum;
  logic [3:0] acc_next;

  // One shared adder handles whichever neighbour pair idx selects this cycle.
  assign pair_bits = nbr_q[{idx, 1'b0} +: 2];
  assign pair_sum  = {2'b00, pair_bits[0]} + {2'b00, pair_bits[1]};
  assign acc_next  = count + {1'b0, pair_sum};

  function automatic logic conway_rule(input logic [3:0] c, input logic a);
    return (c == 4'd3) || ((c == 4'd2) && a);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      nbr_q      <= '0;
      alive_q    <= 1'b0;
      idx        <= '0;
      count      <= '0;
      next_alive <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE_ST: begin
          if (start) begin
            nbr_q      <= neighbors;
            alive_q    <= alive;
            idx        <= '0;
            count      <= '0;
            next_alive <= 1'b0;
            state      <= ACCUM;
            busy       <= 1'b1;
            done       <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ACCUM: begin
          // next_alive tracks the running count so it is final in DONE_ST.
          count      <= acc_next;
          next_alive <= conway_rule(acc_next, alive_q);
          idx        <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= DONE_ST;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_count_sequencer.sv
// Self-checking bench for neighbor_count_sequencer: directed cases, reset
// abort, back-to-back streaming and an exhaustive sweep against a popcount model.
module tb_neighbor_count_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] neighbors;
  logic       alive;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       next_alive;

  int compared;
  int mismatched;

  neighbor_count_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .neighbors  (neighbors),
    .alive      (alive),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .next_alive (next_alive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_count(input logic [7:0] n);
    int c = 0;
    for (int b = 0; b < 8; b++) c += int'(n[b]);
    return c;
  endfunction

  function automatic logic ref_next(input logic [7:0] n, input logic a);
    int c = ref_count(n);
    return (c == 3) || (c == 2 && a);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full evaluation: accept, 4 busy cycles, DONE cycle, then back to IDLE.
  task automatic apply_stimulus(input logic [7:0] n, input logic a, input string tag);
    int exp_c = ref_count(n);
    logic exp_na = ref_next(n, a);
    start = 1'b1;
    neighbors = n;
    alive = a;
    step();
    start = 1'b0;
    neighbors = 8'($urandom);
    alive = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      check_output({tag, " busy"}, 32'(busy), 32'd1);
      check_output({tag, " done_early"}, 32'(done), 32'd0);
      step();
    end
    check_output({tag, " done"}, 32'(done), 32'd1);
    check_output({tag, " busy_off"}, 32'(busy), 32'd0);
    check_output({tag, " count"}, 32'(count), 32'(exp_c));
    check_output({tag, " next_alive"}, 32'(next_alive), 32'(exp_na));
    step();
    check_output({tag, " done_pulse"}, 32'(done), 32'd0);
    check_output({tag, " count_hold"}, 32'(count), 32'(exp_c));
    check_output({tag, " next_hold"}, 32'(next_alive), 32'(exp_na));
  endtask

  initial begin
    logic [7:0] stream_n [3];
    logic       stream_a [3];
    int         done_seen;

    compared   = 0;
    mismatched = 0;
    start      = 1'b0;
    neighbors  = '0;
    alive      = 1'b0;
    rst_n      = 1'b0;

    #12;
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset done", 32'(done), 32'd0);
    check_output("reset count", 32'(count), 32'd0);
    check_output("reset next_alive", 32'(next_alive), 32'd0);

    // Release between edges; the very first edge afterwards must accept START.
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    apply_stimulus(8'b0000_0111, 1'b0, "first_after_reset");

    apply_stimulus(8'hFF, 1'b1, "all_live");
    apply_stimulus(8'b1000_0001, 1'b1, "two_alive");
    apply_stimulus(8'b1000_0001, 1'b0, "two_dead");
    apply_stimulus(8'h00, 1'b1, "none_live");

    // START during cycle 2 of ACCUM with different operands must be ignored.
    start = 1'b1;
    neighbors = 8'b0011_0101;
    alive = 1'b0;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    neighbors = 8'hFF;
    alive = 1'b1;
    step();
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) begin
        done_seen++;
        check_output("ignored_start count", 32'(count), 32'(ref_count(8'b0011_0101)));
        check_output("ignored_start next", 32'(next_alive), 32'(ref_next(8'b0011_0101, 1'b0)));
      end
      step();
    end
    check_output("ignored_start done_count", 32'(done_seen), 32'd1);

    // START held high: one result every 5 cycles, operands swapped in DONE cycle.
    for (int e = 0; e < 3; e++) begin
      stream_n[e] = 8'($urandom);
      stream_a[e] = 1'($urandom);
    end
    start = 1'b1;
    neighbors = stream_n[0];
    alive = stream_a[0];
    step();
    for (int e = 0; e < 3; e++) begin
      neighbors = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        check_output("stream done_early", 32'(done), 32'd0);
        step();
      end
      check_output("stream done", 32'(done), 32'd1);
      check_output("stream count", 32'(count), 32'(ref_count(stream_n[e])));
      check_output("stream next", 32'(next_alive), 32'(ref_next(stream_n[e], stream_a[e])));
      if (e < 2) begin
        neighbors = stream_n[e + 1];
        alive = stream_a[e + 1];
      end else begin
        start = 1'b0;
      end
      step();
    end
    check_output("stream idle_busy", 32'(busy), 32'd0);
    check_output("stream idle_done", 32'(done), 32'd0);

    // Reset mid-ACCUM after two pairs: outputs clear at once, no stray DONE.
    start = 1'b1;
    neighbors = 8'hFF;
    alive = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort busy", 32'(busy), 32'd0);
    check_output("abort done", 32'(done), 32'd0);
    check_output("abort count", 32'(count), 32'd0);
    check_output("abort next_alive", 32'(next_alive), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      step();
    end
    check_output("abort no_done", 32'(done_seen), 32'd0);

    // Exhaustive sweep of every neighbourhood and cell state.
    for (int n = 0; n < 256; n++) begin
      for (int a = 0; a < 2; a++) begin
        apply_stimulus(8'(n), 1'(a), "sweep");
        if ($urandom_range(0, 3) == 0) step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/neighbor_count_sequencer.md
NEIGHBOR_COUNT_SEQUENCER -- requirements
Module: neighbor_count_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 START  input  1  request to evaluate one cell; sampled on the CLK rising edge.
REQ-005 NEIGHBORS  input  8  live/dead states of the 8 neighbours, bit i = neighbour i; sampled with START.
REQ-006 ALIVE  input  1  current state of the cell under evaluation; sampled with START.
REQ-007 BUSY  output  1  high while accumulation is in progress.
REQ-008 DONE  output  1  single-cycle pulse; COUNT and NEXT_ALIVE are valid from this cycle on.
REQ-009 COUNT  output  4  number of live neighbours, 0..8.
REQ-010 NEXT_ALIVE  output  1  next-generation cell state per Conway rules.

Function
REQ-011 The block SHALL implement FSM states IDLE, ACCUM, DONE_ST; encoding is free.
REQ-012 START SHALL be accepted only on an edge where state is IDLE or DONE_ST; acceptance latches NEIGHBORS and ALIVE, clears the accumulator and the pair index, and enters ACCUM.
REQ-013 START on an edge in ACCUM SHALL be ignored; latched operands, accumulator and index are unchanged.
REQ-014 In ACCUM, each edge SHALL add the 2-bit sum NEIGHBORS[2i]+NEIGHBORS[2i+1] (0..2) of pair index i into a 4-bit accumulator, then increment i; i runs 0,1,2,3.
REQ-015 Pair addition SHALL use a single shared 2-bit-to-3-bit add path, with its result zero-extended into the accumulator; the accumulator cannot overflow (max 8).
REQ-016 After the edge that processes i=3, the state SHALL be DONE_ST; acceptance at edge k gives DONE high in the cycle after edge k+4 (latency 4 edges from acceptance, 5 cycles START-to-DONE inclusive).
REQ-017 BUSY SHALL be high exactly in ACCUM (4 cycles per evaluation); it is low in IDLE and DONE_ST.
REQ-018 DONE SHALL be high exactly in DONE_ST, which lasts one cycle: next edge goes to ACCUM if START is accepted, else IDLE.
REQ-019 COUNT SHALL equal the accumulator; it is updated only in ACCUM and holds its final value through DONE_ST and IDLE until the next accepted START clears it.
REQ-020 NEXT_ALIVE SHALL be 1 iff COUNT==3, or COUNT==2 and latched ALIVE==1; it is meaningful only while DONE is high or in IDLE after a completed evaluation.
REQ-021 Back-to-back operation: START held high continuously SHALL yield one evaluation every 5 cycles with no lost or duplicated DONE.
REQ-022 Input changes on NEIGHBORS/ALIVE after acceptance SHALL have no effect on the evaluation in progress.

Reset
REQ-023 RST_N low SHALL immediately (asynchronously) force state IDLE, BUSY=0, DONE=0, COUNT=0, NEXT_ALIVE=0, pair index 0, latched operands 0.
REQ-024 Reset asserted mid-ACCUM SHALL abandon the evaluation; no DONE pulse SHALL follow reset release without a new START.
REQ-025 START sampled on the first edge after RST_N deasserts SHALL be accepted normally.

Verification
REQ-026 NEIGHBORS=8'b0000_0111, ALIVE=0, START one cycle -> BUSY high 4 cycles, then DONE pulse with COUNT=3, NEXT_ALIVE=1.
REQ-027 NEIGHBORS=8'hFF, ALIVE=1 -> COUNT=8, NEXT_ALIVE=0; NEIGHBORS=8'b1000_0001, ALIVE=1 -> COUNT=2, NEXT_ALIVE=1; same with ALIVE=0 -> NEXT_ALIVE=0.
REQ-028 START pulsed again during cycle 2 of ACCUM with different NEIGHBORS -> ignored; original result reported, exactly one DONE.
REQ-029 START held high for 3 evaluations with NEIGHBORS changing each DONE cycle -> DONE every 5 cycles, COUNT matching each operand set in order.
REQ-030 RST_N pulled low during ACCUM (after 2 pairs) -> outputs zero at once; no DONE for 10 cycles after release without START.
REQ-031 Exhaustive: all 256 NEIGHBORS values x ALIVE 0/1 -> COUNT equals popcount, NEXT_ALIVE matches Conway rule.
